// File: rtl/rv16_fetch_aligner_if.sv
// Bundles the redirect, instruction-memory and decoder handshake signals of the rv16 fetch aligner.
// The master modport is the aligner; the slave modport is its surroundings (core control, imem, decoder).
interface rv16_fetch_aligner_if;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_rvalid;
  logic [31:0] i_imem_rdata;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_instruction;
  logic        o_is_compressed;
  logic [31:0] o_pc;

  modport master (
    input  i_redirect, i_redirect_pc, i_imem_rvalid, i_imem_rdata, i_ready,
    output o_imem_req, o_imem_addr, o_valid, o_instruction, o_is_compressed, o_pc
  );

  modport slave (
    output i_redirect, i_redirect_pc, i_imem_rvalid, i_imem_rdata, i_ready,
    input  o_imem_req, o_imem_addr, o_valid, o_instruction, o_is_compressed, o_pc
  );
endinterface

// File: rtl/rv16_fetch_aligner.sv
// rv16 fetch aligner: word reads from imem, a 3-halfword buffer, and whole 16/32-bit
// instructions presented to the decoder, with redirect and stale-read squashing.
//
// state       | meaning
// RUN         | no read outstanding; request when buffer holds <= 1 halfword
// WAIT        | one read outstanding; its data is appended on return
// WAIT_SQUASH | one read outstanding but stale after a redirect; data is dropped
module rv16_fetch_aligner #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  rv16_fetch_aligner_if.master  bus
);

  typedef enum logic [1:0] {
    RUN         = 2'd0,
    WAIT        = 2'd1,
    WAIT_SQUASH = 2'd2
  } state_t;

  state_t            state;
  logic [2:0][15:0]  hw;
  logic [1:0]        count;
  logic [31:0]       pc;
  logic [31:0]       fetch_addr;
  logic              discard_low;
  logic              imem_req;

  logic              is_c;
  logic              valid;
  logic              fire;
  logic [1:0]        consume;
  logic [1:0]        rem;
  logic              append_en;
  logic [2:0][15:0]  shifted;
  logic [2:0][15:0]  nb;
  logic [1:0]        nc;
  logic [31:0]       pc_step;

  assign is_c      = (hw[0][1:0] != 2'b11);
  assign valid     = !bus.i_redirect && (((count >= 2'd1) && is_c) || (count >= 2'd2));
  assign fire      = valid && bus.i_ready;
  assign consume   = fire ? (is_c ? 2'd1 : 2'd2) : 2'd0;
  assign rem       = count - consume;
  assign append_en = (state == WAIT) && bus.i_imem_rvalid;
  assign pc_step   = is_c ? 32'd2 : 32'd4;

  // Consume from the head first, then append the returned halfwords behind what remains.
  always_comb begin
    shifted = hw;
    if (consume == 2'd1) begin
      shifted = {16'h0000, hw[2], hw[1]};
    end else if (consume == 2'd2) begin
      shifted = {16'h0000, 16'h0000, hw[2]};
    end
    nb = shifted;
    nc = rem;
    if (append_en && (rem != 2'd3)) begin
      if (discard_low) begin
        nb[rem] = bus.i_imem_rdata[31:16];
        nc      = rem + 2'd1;
      end else begin
        nb[rem] = bus.i_imem_rdata[15:0];
        if (rem < 2'd2) begin
          nb[rem + 2'd1] = bus.i_imem_rdata[31:16];
        end
        nc = rem + 2'd2;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= RUN;
      hw          <= '0;
      count       <= 2'd0;
      pc          <= {RESET_PC[31:1], 1'b0};
      fetch_addr  <= {RESET_PC[31:2], 2'b00};
      discard_low <= RESET_PC[1];
      imem_req    <= 1'b0;
    end else if (bus.i_redirect) begin
      count       <= 2'd0;
      pc          <= {bus.i_redirect_pc[31:1], 1'b0};
      fetch_addr  <= {bus.i_redirect_pc[31:2], 2'b00};
      discard_low <= bus.i_redirect_pc[1];
      imem_req    <= 1'b0;
      // A read still in flight must be swallowed unless it returns this very cycle.
      if ((state != RUN) && !bus.i_imem_rvalid) begin
        state <= WAIT_SQUASH;
      end else begin
        state <= RUN;
      end
    end else begin
      hw       <= nb;
      count    <= nc;
      imem_req <= 1'b0;
      if (fire) begin
        pc <= pc + pc_step;
      end
      case (state)
        RUN: begin
          if (count <= 2'd1) begin
            imem_req <= 1'b1;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (bus.i_imem_rvalid) begin
            fetch_addr  <= fetch_addr + 32'd4;
            discard_low <= 1'b0;
            state       <= RUN;
          end
        end
        WAIT_SQUASH: begin
          if (bus.i_imem_rvalid) begin
            state <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  assign bus.o_valid         = valid;
  assign bus.o_is_compressed = (count != 2'd0) && is_c;
  assign bus.o_instruction   = (count == 2'd0) ? 32'h0 :
                               (is_c ? {16'h0000, hw[0]} : {hw[1], hw[0]});
  assign bus.o_pc            = pc;
  assign bus.o_imem_req      = imem_req;
  assign bus.o_imem_addr     = fetch_addr;

endmodule

// File: doc/rv16_fetch_aligner.md
Name: rv16_fetch_aligner

Overview:
- Fetch stage directly upstream of the rv16 instruction decoder.
- Issues word-aligned reads to instruction memory and buffers the returned halfwords.
- Presents one whole instruction per handshake, either 16-bit compressed or 32-bit, with its PC and an is-compressed flag; 32-bit instructions may straddle a word boundary.
- Handles branch/jump redirects, including halfword-aligned targets and squashing of in-flight stale reads.

Parameters:
RESET_PC, 32'h0000_0000, PC of the first instruction after reset (bit 0 ignored).

Ports:
i_clk  input  1  clock, rising edge.
i_rst_n  input  1  asynchronous active-low reset.
i_redirect  input  1  flush and restart fetch at i_redirect_pc.
i_redirect_pc  input  32  redirect target; bit 0 ignored, bit 1 honoured.
o_imem_req  output  1  one-cycle read request pulse.
o_imem_addr  output  32  word-aligned read address, valid with o_imem_req.
i_imem_rvalid  input  1  read data valid; exactly one per request, in order, no earlier than 1 cycle after the request.
i_imem_rdata  input  32  read word; low halfword is at the lower address.
o_valid  output  1  o_instruction/o_is_compressed/o_pc hold a complete instruction.
i_ready  input  1  downstream accepts; a transfer occurs when o_valid && i_ready.
o_instruction  output  32  compressed: {16'h0, hw}; full: {hw_hi, hw_lo}.
o_is_compressed  output  1  1 when the instruction's bits[1:0] != 2'b11.
o_pc  output  32  address of the presented instruction.

Behaviour:
- Reset is asynchronous on the falling edge of i_rst_n and takes effect immediately. Reset values:
  - buffer count 0, state RUN, squash flag 0, discard_low = RESET_PC[1].
  - pc = RESET_PC & ~1; fetch address = {RESET_PC[31:2], 2'b00}.
  - o_valid 0, o_imem_req 0, o_instruction 0, o_is_compressed 0.
  - o_pc = pc; o_imem_addr = fetch address.
- Buffer holds up to 3 halfwords (hw0 is oldest) plus a count of 0..3.
- Memory FSM:
  - RUN (nothing outstanding): when count <= 1 and i_redirect = 0, pulse o_imem_req for one cycle at the fetch address, then go to WAIT.
  - WAIT: on i_imem_rvalid, append the returned halfwords, advance the fetch address by 4, return to RUN. A new request may issue in the cycle after the response, never in the same cycle.
  - WAIT_SQUASH: the outstanding response is stale. On i_imem_rvalid, discard the data and go to RUN.
- Append rule: append both halfwords (low first). If discard_low = 1, append only the high halfword, then clear discard_low.
- Output logic (combinational from registers):
  - o_valid = !i_redirect && ((count >= 1 && hw0[1:0] != 2'b11) || count >= 2).
  - 32-bit instruction with count = 1: o_valid = 0 until the next response arrives (straddle case).
- Transfer: shift out 1 or 2 halfwords and advance pc by 2 or 4. A transfer and an append in the same cycle are allowed: consume first, then append. Count never exceeds 3.
- Outputs remain stable while o_valid && !i_ready.
- Redirect has priority over both transfer and append:
  - count := 0; pc := i_redirect_pc & ~1; fetch address := {i_redirect_pc[31:2], 2'b00}; discard_low := i_redirect_pc[1].
  - If in WAIT or WAIT_SQUASH, go to WAIT_SQUASH; otherwise stay in RUN. No request is issued in the redirect cycle.
  - A response arriving in the redirect cycle is discarded, and the FSM goes to RUN.
- i_imem_rvalid while in RUN (no outstanding request) is ignored.
- pc and fetch address wrap modulo 2^32.

Test Plan:
1. Full word: reset; word @0x0 = 0x00A00093 -> single request to addr 0x0; o_instruction 0x00A00093, o_is_compressed 0, o_pc 0x0; next request to addr 0x4.
2. Two compressed: word 0x45050485 -> {16'h0, 0x0485} at pc 0x0, then {16'h0, 0x4505} at pc 0x2, both with o_is_compressed 1.
3. Straddle: words 0x00930001 and 0x000100A0 -> c.nop at pc 0x0; o_valid low until the second word returns; then 0x00A00093 at pc 0x2; then 0x0001 at pc 0x6.
4. Backpressure: i_ready low for 5 cycles -> outputs stable; exactly one request outstanding; no request issued while count >= 2; count <= 3.
5. Redirect to 0x102 while a read of 0x8 is outstanding:
   - the 0x8 data is dropped;
   - the next request goes to 0x100 after that response;
   - word 0x12340001 yields 0x1234 presented at pc 0x102.
6. Assert i_rst_n low while in WAIT -> outputs return to reset values immediately; a late rvalid is ignored; fetch restarts at RESET_PC.
